// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// The table layout, the counter encoding and the counter update rule live here.
package bp_pkg;

  localparam int IDX_W = 6;
  // Wide enough for the tag at any index width. Narrower tags are zero-extended.
  localparam int TAG_W = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  typedef struct packed {
    logic             valid;
    bp_cnt_t          cnt;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } bp_entry_t;

  function automatic bp_cnt_t sat_update(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t nxt;
    case (cnt)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      default: nxt = taken ? ST  : WT;
    endcase
    return nxt;
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc, input int idx_w);
    return TAG_W'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/bp_if.sv
// Fetch/decode-side signal bundle of the branch predictor.
// The core holds the master side and the predictor holds the slave side.
interface bp_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid;
  logic        id_stall;
  logic        id_is_branch;
  logic        id_is_bne;
  logic        id_zero;
  logic [31:0] id_pc;
  logic [31:0] id_target;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output if_pc, id_valid, id_stall, id_is_branch, id_is_bne, id_zero,
           id_pc, id_target, id_pred_taken, id_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_is_branch, id_is_bne, id_zero,
           id_pc, id_target, id_pred_taken, id_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped counter/target table. It has two combinational read ports
// (fetch lookup and ID resolve), one synchronous write port and a synchronous clear.
module bp_btb import bp_pkg::*; #(
  parameter int IDX_W = bp_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_a_idx,
  output bp_entry_t        rd_a,
  input  logic [IDX_W-1:0] rd_b_idx,
  output bp_entry_t        rd_b,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  bp_entry_t        wr_entry
);

  localparam int DEPTH = 1 << IDX_W;
  localparam bp_entry_t CLEAR_ENTRY = '{valid: 1'b0, cnt: WNT, tag: '0, target: '0};

  bp_entry_t mem [DEPTH];

  // Reads return the stored value, so a same-cycle write is visible only after the edge.
  assign rd_a = mem[rd_a_idx];
  assign rd_b = mem[rd_b_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= CLEAR_ENTRY;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage beq/bne predictor: it looks up the table, detects mispredictions in ID
// against the comparator, trains the table and keeps saturating statistics.
module branch_predictor import bp_pkg::*; #(
  parameter int IDX_W = bp_pkg::IDX_W
) (
  input logic  clk,
  input logic  rst_n,
  bp_if.slave  bus
);

  bp_entry_t        look_e;
  bp_entry_t        res_e;
  bp_entry_t        upd_e;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] id_tag;
  logic             res;
  logic             taken;
  logic             hit;
  logic             mispredict;
  logic [31:0]      stat_branches_q;
  logic [31:0]      stat_mispredicts_q;

  assign if_tag = tag_of(bus.if_pc, IDX_W);
  assign id_tag = tag_of(bus.id_pc, IDX_W);

  bp_btb #(.IDX_W(IDX_W)) u_btb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_a_idx (bus.if_pc[IDX_W+1:2]),
    .rd_a     (look_e),
    .rd_b_idx (bus.id_pc[IDX_W+1:2]),
    .rd_b     (res_e),
    .wr_en    (res),
    .wr_idx   (bus.id_pc[IDX_W+1:2]),
    .wr_entry (upd_e)
  );

  assign bus.pred_taken  = look_e.valid && (look_e.tag == if_tag) &&
                           (look_e.cnt == WT || look_e.cnt == ST);
  assign bus.pred_target = look_e.target;

  assign res   = bus.id_valid & bus.id_is_branch & ~bus.id_stall;
  assign taken = bus.id_is_bne ? ~bus.id_zero : bus.id_zero;

  // A correct direction with a stale target is still a redirect.
  assign mispredict = res & ((taken != bus.id_pred_taken) |
                      (taken & bus.id_pred_taken & (bus.id_target != bus.id_pred_target)));

  assign bus.mispredict  = mispredict;
  assign bus.redirect_pc = taken ? bus.id_target : bus.id_pc + 32'd4;

  // A tag miss reallocates the entry with a weak counter biased toward this outcome.
  assign hit = res_e.valid && (res_e.tag == id_tag);

  always_comb begin
    upd_e        = res_e;
    upd_e.valid  = 1'b1;
    upd_e.tag    = id_tag;
    upd_e.cnt    = hit ? sat_update(res_e.cnt, taken) : (taken ? WT : WNT);
    if (taken) upd_e.target = bus.id_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (res) begin
      if (stat_branches_q != 32'hFFFF_FFFF)
        stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict && stat_mispredicts_q != 32'hFFFF_FFFF)
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor.
// It checks against an array-based reference model of the prediction and training rules.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  bp_if bus ();

  branch_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state, indexed by pc[7:2]
  bit          m_valid [64];
  int          m_cnt   [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == int'(pc >> 8)) && (m_cnt[i] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_cnt[i] = 1; m_tag[i] = 0; m_tgt[i] = 32'h0;
    end
    m_br = 0; m_mp = 0;
  endtask

  function automatic bit m_res();
    return bus.id_valid && bus.id_is_branch && !bus.id_stall;
  endfunction

  function automatic bit m_taken();
    return bus.id_is_bne ? !bus.id_zero : bus.id_zero;
  endfunction

  function automatic bit m_mispred();
    bit t = m_taken();
    if (!m_res()) return 0;
    if (t != bus.id_pred_taken) return 1;
    return t && (bus.id_target != bus.id_pred_target);
  endfunction

  // Compare all combinational outputs against the model, with the model in its pre-edge state
  task automatic eval();
    logic [31:0] exp_redir;
    bit p;
    #1;
    p = m_pred(bus.if_pc);
    chk("pred_taken", {31'b0, bus.pred_taken}, {31'b0, p});
    if (p) chk("pred_target", bus.pred_target, m_tgt[idx_of(bus.if_pc)]);
    chk("mispredict", {31'b0, bus.mispredict}, {31'b0, m_mispred()});
    exp_redir = m_taken() ? bus.id_target : bus.id_pc + 32'd4;
    chk("redirect_pc", bus.redirect_pc, exp_redir);
    chk("stat_branches", bus.stat_branches, m_br);
    chk("stat_mispredicts", bus.stat_mispredicts, m_mp);
  endtask

  task automatic advance();
    int i;
    bit t, mp;
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else if (m_res()) begin
      i  = idx_of(bus.id_pc);
      t  = m_taken();
      mp = m_mispred();
      if (m_valid[i] && m_tag[i] == int'(bus.id_pc >> 8))
        m_cnt[i] = t ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
      else
        m_cnt[i] = t ? 2 : 1;
      m_valid[i] = 1;
      m_tag[i]   = int'(bus.id_pc >> 8);
      if (t) m_tgt[i] = bus.id_target;
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (mp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] pc);
    bus.if_pc = pc; bus.id_valid = 0; bus.id_stall = 0; bus.id_is_branch = 0;
    bus.id_is_bne = 0; bus.id_zero = 0; bus.id_pc = 32'h0040_0100; bus.id_target = 32'h0;
    bus.id_pred_taken = 0; bus.id_pred_target = 32'h0;
  endtask

  task automatic branch(input logic [31:0] pc, input logic [31:0] tgt, input bit bne,
                        input bit zero, input bit ptk, input logic [31:0] ptgt, input bit stall);
    bus.id_valid = 1; bus.id_is_branch = 1; bus.id_stall = stall; bus.id_is_bne = bne;
    bus.id_zero = zero; bus.id_pc = pc; bus.id_target = tgt;
    bus.id_pred_taken = ptk; bus.id_pred_target = ptgt;
  endtask

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0110;
  localparam logic [31:0] TG_A = 32'h0040_0040;
  localparam logic [31:0] TG_B = 32'h0040_0200;

  initial begin
    m_reset();
    rst_n = 0;
    idle(PC_A);
    @(negedge clk);
    advance();
    advance();
    rst_n = 1;

    // Reset state
    idle(PC_A);
    eval();
    chk("rst_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("rst_stat_br", bus.stat_branches, 32'd0);
    chk("rst_stat_mp", bus.stat_mispredicts, 32'd0);
    advance();

    // Cold taken beq
    branch(PC_A, TG_A, 0, 1, 0, 32'h0, 0);
    eval();
    chk("cold_mispredict", {31'b0, bus.mispredict}, 32'd1);
    chk("cold_redirect", bus.redirect_pc, TG_A);
    advance();
    idle(PC_A);
    eval();
    chk("cold_next_pred", {31'b0, bus.pred_taken}, 32'd1);
    chk("cold_next_target", bus.pred_target, TG_A);
    advance();

    // Saturate upward, then one not-taken
    for (int k = 0; k < 4; k++) begin
      branch(PC_A, TG_A, 0, 1, 1, TG_A, 0);
      eval();
      advance();
    end
    branch(PC_A, TG_A, 0, 0, 1, TG_A, 0);
    eval();
    chk("sat_nt_mispredict", {31'b0, bus.mispredict}, 32'd1);
    chk("sat_nt_redirect", bus.redirect_pc, 32'h0040_0014);
    advance();
    idle(PC_A);
    eval();
    chk("sat_after_nt_pred", {31'b0, bus.pred_taken}, 32'd1);
    advance();

    // bne with rs==rt resolves not-taken
    branch(PC_A, TG_A, 1, 1, 0, 32'h0, 0);
    eval();
    chk("bne_no_mispredict", {31'b0, bus.mispredict}, 32'd0);
    advance();
    idle(PC_A);
    eval();
    chk("bne_decremented", {31'b0, bus.pred_taken}, 32'd0);
    advance();

    // A stalled resolve changes nothing
    branch(PC_A, TG_A, 0, 1, 0, 32'h0, 1);
    eval();
    chk("stall_no_mispredict", {31'b0, bus.mispredict}, 32'd0);
    advance();
    idle(PC_A);
    eval();
    chk("stall_pred", {31'b0, bus.pred_taken}, 32'd0);
    chk("stall_stat_br", bus.stat_branches, 32'd7);
    chk("stall_stat_mp", bus.stat_mispredicts, 32'd2);
    advance();

    // Aliasing with a read-before-write lookup
    branch(PC_A, TG_A, 0, 1, 0, 32'h0, 0);
    eval();
    advance();
    branch(PC_B, TG_B, 0, 1, 0, 32'h0, 0);
    bus.if_pc = PC_A;
    eval();
    chk("rbw_old_pred", {31'b0, bus.pred_taken}, 32'd1);
    chk("rbw_old_target", bus.pred_target, TG_A);
    advance();
    idle(PC_A);
    eval();
    chk("alias_evicted", {31'b0, bus.pred_taken}, 32'd0);
    advance();
    idle(PC_B);
    eval();
    chk("alias_new_pred", {31'b0, bus.pred_taken}, 32'd1);
    chk("alias_new_target", bus.pred_target, TG_B);
    advance();

    // Right direction with the wrong target
    branch(PC_B, TG_B, 0, 1, 1, 32'h0040_0300, 0);
    eval();
    chk("tgt_mismatch_mp", {31'b0, bus.mispredict}, 32'd1);
    chk("tgt_mismatch_redir", bus.redirect_pc, TG_B);
    advance();

    // Randomized traffic, including occasional mid-run resets
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc, ipc;
      pc  = 32'h0040_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
      ipc = 32'h0040_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
      rst_n = ($urandom_range(0, 49) != 0);
      bus.if_pc        = ipc;
      bus.id_valid     = ($urandom_range(0, 7) != 0);
      bus.id_is_branch = ($urandom_range(0, 3) != 0);
      bus.id_stall     = ($urandom_range(0, 7) == 0);
      bus.id_is_bne    = 1'($urandom_range(0, 1));
      bus.id_zero      = 1'($urandom_range(0, 1));
      bus.id_pc        = pc;
      bus.id_target    = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 4);
      if ($urandom_range(0, 3) != 0) begin
        bus.id_pred_taken  = m_pred(pc);
        bus.id_pred_target = m_tgt[idx_of(pc)];
      end else begin
        bus.id_pred_taken  = 1'($urandom_range(0, 1));
        bus.id_pred_target = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 4);
      end
      eval();
      advance();
    end
    rst_n = 1;

    // Statistics saturation
    idle(PC_A);
    force dut.stat_branches_q = 32'hFFFF_FFFF;
    force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branches_q;
    release dut.stat_mispredicts_q;
    m_br = 32'hFFFF_FFFF;
    m_mp = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      branch(PC_A, TG_A, 0, 1, ~m_pred(PC_A), TG_A, 0);
      eval();
      advance();
    end
    idle(PC_A);
    eval();
    chk("sat_stat_br", bus.stat_branches, 32'hFFFF_FFFF);
    chk("sat_stat_mp", bus.stat_mispredicts, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
